// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM state type for the vector memory access arbiter.
package mem_arb_pkg;
   localparam int LANES      = 16;
   localparam int WORD_W     = 32;
   localparam int DATA_W     = LANES * WORD_W;
   localparam int ADDR_W     = 9;
   localparam int DEPTH      = 512;
   localparam int WRAP_LIMIT = 496;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;
endpackage

// File: rtl/mem_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at the pointer, pointer moves past the winner on grant_en.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               grant_en,
   output logic [NUM_REQ-1:0] grant
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win;
   logic             found;

   // Scan offsets from the pointer outward; the first valid requester wins.
   always_comb begin
      grant = '0;
      win   = '0;
      found = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i == (int'(ptr) + off) % NUM_REQ)) begin
               grant[i] = 1'b1;
               win      = PTR_W'(i);
               found    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (grant_en) begin
         ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
      end
   end
endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates NUM_REQ requesters onto one 16-lane vector memory: IDLE -> ACCESS -> RESP, 2-cycle latency.
// Optional MEM_ARB_WRAP_CHECK_EN flags addresses above WRAP_LIMIT as errors instead of wrapping.
module mem_access_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
   parameter int DATA_W  = mem_arb_pkg::DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_we,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy
);
   import mem_arb_pkg::*;

   state_t              state, state_nxt;
   logic [NUM_REQ-1:0]  grant;
   logic [NUM_REQ-1:0]  owner;
   logic                accept;
   logic                acc_err;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .clk      (clk),
      .reset    (reset),
      .req      (req_valid),
      .grant_en (accept),
      .grant    (grant)
   );

   // Ready only leaves the block in IDLE, so the grant itself is the handshake.
   assign req_ready = (state == ST_IDLE && !reset) ? grant : '0;
   assign accept    = (state == ST_IDLE) && !reset && (|grant);

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
         ST_ACCESS: state_nxt = ST_RESP;
         ST_RESP:   if (|(rsp_ready & owner)) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            owner     <= grant;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
         end
         // Write data is already committed by the mid-cycle negedge, so this is the read-back.
         if (state == ST_ACCESS) begin
            rsp_rdata <= acc_err ? '0 : mem_rdata;
         end
      end
   end

`ifdef MEM_ARB_WRAP_CHECK_EN
   logic err_q;
   logic rsp_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q     <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         if (accept) begin
            err_q <= (int'(sel_addr) > WRAP_LIMIT);
         end
         if (state == ST_ACCESS) begin
            rsp_err_q <= err_q;
         end
      end
   end

   assign acc_err = err_q;
   assign rsp_err = rsp_err_q;
`else
   assign acc_err = 1'b0;
   assign rsp_err = 1'b0;
`endif

   assign rsp_valid = (state == ST_RESP) ? owner : '0;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign mem_we    = (state == ST_ACCESS) && lat_we && !acc_err;
   assign busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: vector memory model, per-cycle transaction-level model, literal spot checks.
module tb_mem_access_arbiter;
   localparam int N  = 2;
   localparam int AW = 9;
   localparam int DW = 512;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
   logic            rsp_err, mem_we, busy;
   logic [AW-1:0]   mem_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // 512 x 32-bit store; a vector covers 16 consecutive words, wrapping modulo 512.
   logic [31:0] mem [512];
   initial for (int i = 0; i < 512; i++) mem[i] = 32'h0;

   always @(negedge clk) begin
      if (mem_we === 1'b1)
         for (int l = 0; l < 16; l++) mem[(int'(mem_addr) + l) % 512] <= mem_wdata[l*32 +: 32];
   end

   always_comb begin
      mem_rdata = '0;
      for (int l = 0; l < 16; l++) mem_rdata[l*32 +: 32] = mem[(int'(mem_addr) + l) % 512];
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [511:0] vec(input int base);
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(base + i);
      return v;
   endfunction

   // Transaction-level model: phase 0 idle, 1 memory access, 2 response pending.
   int           m_phase = 0, m_ptr = 0, m_owner = 0;
   bit           m_init = 0, m_we = 0, m_err = 0, m_rsp_err = 0;
   logic [8:0]   m_addr;
   logic [511:0] m_wdata, m_rdata;
   logic [31:0]  ref_mem [512];
   initial for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;

   always @(negedge clk) begin
      int win;
      win = -1;
      if (m_phase == 0)
         for (int k = 0; k < N; k++)
            if (win < 0 && req_valid[(m_ptr + k) % N] === 1'b1) win = (m_ptr + k) % N;
      if (m_init) begin
         check("req_ready", req_ready, (m_phase == 0 && !reset && win >= 0) ? 2'(1 << win) : 2'b00);
         check("busy", busy, m_phase != 0);
         check("rsp_valid", rsp_valid, (m_phase == 2) ? 2'(1 << m_owner) : 2'b00);
         check("mem_we", mem_we, m_phase == 1 && m_we && !m_err);
         check("rsp_rdata", rsp_rdata, m_rdata);
         check("rsp_err", rsp_err, m_rsp_err);
         if (m_phase == 1) check("mem_addr", mem_addr, m_addr);
         if (m_phase == 1 && m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_phase == 1 && m_we && !m_err)
         for (int l = 0; l < 16; l++) ref_mem[(int'(m_addr) + l) % 512] = m_wdata[l*32 +: 32];
      if (reset) begin
         m_phase = 0; m_ptr = 0; m_rdata = '0; m_rsp_err = 0; m_err = 0; m_init = 1;
      end else begin
         case (m_phase)
            0: if (win >= 0) begin
                  m_owner = win;
                  m_we    = req_we[win];
                  m_addr  = req_addr[win*AW +: AW];
                  m_wdata = req_wdata[win*DW +: DW];
`ifdef MEM_ARB_WRAP_CHECK_EN
                  m_err   = (int'(m_addr) > 496);
`else
                  m_err   = 0;
`endif
                  m_ptr   = (win + 1) % N;
                  m_phase = 1;
               end
            1: begin
                  for (int l = 0; l < 16; l++)
                     m_rdata[l*32 +: 32] = m_err ? 32'h0 : ref_mem[(int'(m_addr) + l) % 512];
                  m_rsp_err = m_err;
                  m_phase   = 2;
               end
            default: if (rsp_ready[m_owner] === 1'b1) m_phase = 0;
         endcase
      end
   end

   // Issue one request; returns at the first negedge showing its response.
   task automatic issue(input int r, input bit we, input logic [8:0] a, input logic [511:0] d,
                        output int lat, output logic [511:0] rd);
      int n;
      @(posedge clk); #1;
      req_we[r] = we;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*DW +: DW] = d;
      req_valid[r] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready[r] !== 1'b1 && n < 50);
      check("accept", req_ready[r], 1'b1);
      @(posedge clk); #1 req_valid[r] = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (rsp_valid[r] !== 1'b1 && lat < 20);
      check("rsp_arrive", rsp_valid[r], 1'b1);
      rd = rsp_rdata;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 50);
      check("idle_wait", busy, 1'b0);
   endtask

   initial begin
      int           lat, n, ng;
      int           grants [4];
      logic [511:0] rd, r0;

      reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_rsp_valid", rsp_valid, 2'b00);
      check("reset_rdata", rsp_rdata, 512'h0);

      // Write then read back at 0x010
      issue(0, 1'b1, 9'h010, vec(1), lat, rd);
      check("wr_latency", lat, 2);
      check("wr_rd_lane0", rd[31:0], 32'd1);
      check("wr_rd_lane15", rd[511:480], 32'd16);
      check("mem_0x10", mem[16], 32'd1);
      check("mem_0x1f", mem[31], 32'd16);
      issue(1, 1'b0, 9'h010, '0, lat, rd);
      check("rd_latency", lat, 2);
      check("rd_match", rd, vec(1));

      // Contention: both valid for four transactions
      @(posedge clk); #1;
      req_we = '0; req_addr = {9'h010, 9'h010}; req_valid = 2'b11;
      ng = 0; n = 0;
      while (ng < 4 && n < 200) begin
         @(negedge clk); n++;
         check("one_ready", ($countones(req_ready) <= 1), 1'b1);
         if (req_ready != 2'b00) begin grants[ng] = req_ready[1] ? 1 : 0; ng++; end
      end
      @(posedge clk); #1 req_valid = 2'b00;
      check("grant_count", ng, 4);
      check("grant0", grants[0], 0);
      check("grant1", grants[1], 1);
      check("grant2", grants[2], 0);
      check("grant3", grants[3], 1);
      wait_idle();

      // Response backpressure on requester 1 with requester 0 waiting
      @(posedge clk); #1;
      rsp_ready = 2'b01; req_we = '0; req_addr = {9'h010, 9'h010}; req_valid = 2'b10;
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready[1] !== 1'b1 && n < 50);
      check("bp_accept", req_ready[1], 1'b1);
      @(posedge clk); #1 req_valid = 2'b01;
      n = 0;
      do begin @(negedge clk); n++; end while (rsp_valid[1] !== 1'b1 && n < 20);
      check("bp_rsp", rsp_valid[1], 1'b1);
      r0 = rsp_rdata;
      check("bp_data0", r0, vec(1));
      repeat (4) begin
         @(negedge clk);
         check("bp_hold_valid", rsp_valid, 2'b10);
         check("bp_hold_data", rsp_rdata, r0);
         check("bp_no_grant", req_ready, 2'b00);
      end
      @(posedge clk); #1 rsp_ready = 2'b11;
      @(negedge clk);
      check("bp_last_valid", rsp_valid, 2'b10);
      @(negedge clk);
      check("bp_idle", busy, 1'b0);
      check("bp_waiter_grant", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = 2'b00;
      wait_idle();

      // Wrap at 0x1F8
      issue(0, 1'b1, 9'h1F8, vec(32'hA000), lat, rd);
`ifdef MEM_ARB_WRAP_CHECK_EN
      check("wrap_err_rdata", rd, 512'h0);
      check("wrap_err_mem0", mem[0], 32'h0);
      check("wrap_err_mem1f8", mem[504], 32'h0);
`else
      check("wrap_rd_lane0", rd[31:0], 32'hA000);
      check("wrap_mem1f8", mem[504], 32'hA000);
      check("wrap_mem1ff", mem[511], 32'hA007);
      check("wrap_mem0", mem[0], 32'hA008);
      check("wrap_mem7", mem[7], 32'hA00F);
`endif

      // Reset while a write response to 0x020 is pending
      @(posedge clk); #1 rsp_ready = 2'b10;
      issue(0, 1'b1, 9'h020, vec(32'h200), lat, rd);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; rsp_ready = 2'b11;
      @(negedge clk);
      check("rst_resp_valid", rsp_valid, 2'b00);
      check("rst_resp_busy", busy, 1'b0);
      issue(1, 1'b0, 9'h020, '0, lat, rd);
      check("rst_resp_readback", rd[31:0], 32'h200);
      check("rst_resp_readback_vec", rd, vec(32'h200));

      // Reset during the ACCESS cycle of a write to 0x040
      @(posedge clk); #1;
      req_we[0] = 1'b1; req_addr[8:0] = 9'h040; req_wdata[511:0] = vec(32'h400); req_valid[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready[0] !== 1'b1 && n < 50);
      check("rst_acc_accept", req_ready[0], 1'b1);
      @(posedge clk); #1 req_valid[0] = 1'b0; reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_acc_no_rsp", rsp_valid, 2'b00);
         check("rst_acc_busy", busy, 1'b0);
      end
      check("rst_acc_mem40", mem[64], 32'h400);
      check("rst_acc_mem4f", mem[79], 32'h40F);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
